// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - shared types and constants for the triangle-from-sides block
// Holds the controller state enum and the default widths. CW is the width of a
// fixed-point coordinate magnitude (integer bits plus fractional bits).
package tri_pkg;

  localparam int W_DEFAULT    = 8;
  localparam int FRAC_DEFAULT = 4;
  localparam int CW           = W_DEFAULT + FRAC_DEFAULT;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV   = 3'd2,
    SQRT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - bit-serial floor integer square root, one result bit per cycle
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request; radicand is sampled and the first root bit
//                is resolved on this same edge
//   radicand   : 2*ROOT_W-bit unsigned operand
//   done       : one-cycle pulse, root is final from this cycle on
//   root       : floor(sqrt(radicand)), held until the next start
module isqrt_seq
  import tri_pkg::*;
#(
  parameter int ROOT_W = CW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic                  done,
  output logic [ROOT_W-1:0]     root
);

  // Partial remainder never exceeds 2*root, so ROOT_W+1 bits hold it; the
  // accumulator gets two more bits for the incoming radicand pair.
  localparam int RMW  = ROOT_W + 3;
  localparam int CNTW = $clog2(ROOT_W) + 1;

  logic [RMW-3:0]        rem_q;
  logic [RMW-3:0]        rem_n;
  logic [ROOT_W-1:0]     root_q;
  logic [ROOT_W-1:0]     root_n;
  logic [2*ROOT_W-1:0]   sh_q;
  logic [CNTW-1:0]       cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic [1:0]            pair;
  logic [RMW-1:0]        acc;
  logic [RMW-1:0]        trial;
  logic                  take;

  always_comb begin
    pair  = start ? radicand[2*ROOT_W-1 -: 2] : sh_q[2*ROOT_W-1 -: 2];
    acc   = {(start ? {(RMW-2){1'b0}} : rem_q), pair};
    trial = {1'b0, (start ? {ROOT_W{1'b0}} : root_q), 2'b01};
    take  = (acc >= trial);
    rem_n = take ? (RMW-2)'(acc - trial) : acc[RMW-3:0];
    if (start) begin
      root_n = {{(ROOT_W-1){1'b0}}, take};
    end else begin
      root_n = {root_q[ROOT_W-2:0], take};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      root_q <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_n;
      root_q <= root_n;
      sh_q   <= {radicand[2*ROOT_W-3:0], 2'b00};
      cnt_q  <= CNTW'(1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q  <= rem_n;
      root_q <= root_n;
      sh_q   <= {sh_q[2*ROOT_W-3:0], 2'b00};
      cnt_q  <= cnt_q + CNTW'(1);
      if (cnt_q == CNTW'(ROOT_W - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done = done_q;
  assign root = root_q;

endmodule

// File: rtl/tri_from_sides.sv
// rtl/tri_from_sides.sv - rebuild triangle vertices from three side lengths
// Frame: A at origin, B on +x, C in the upper half-plane. Coordinates in Q(FRAC).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid/in_ready       : side triple handshake (side_a=BC, side_b=CA, side_c=AB)
//   out_valid/out_ready     : result handshake
//   bx  (signed)            : B.x = side_c << FRAC
//   cx  (signed)            : C.x = (b^2 + c^2 - a^2) / (2c), truncated toward zero
//   cy  (unsigned)          : C.y = floor(sqrt((b<<FRAC)^2 - cx^2))
//   err                     : triple violates the strict triangle inequality
module tri_from_sides
  import tri_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          side_a,
  input  logic [W-1:0]          side_b,
  input  logic [W-1:0]          side_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W+FRAC:0]       bx,
  output logic [W+FRAC:0]       cx,
  output logic [W+FRAC-1:0]     cy,
  output logic                  err
);

  localparam int CWD  = W + FRAC;
  localparam int NW   = 2*W + 2;
  localparam int DW   = NW + FRAC;
  // |cx| < 16*b, so the quotient fits CWD bits and the top DW-CWD dividend
  // bits are already smaller than the divisor: they seed the remainder.
  localparam int RW   = DW - CWD + 1;
  localparam int CNTW = $clog2(CWD) + 1;

  state_t              state, state_n;
  logic [W-1:0]        ra, rb, rc;
  logic [RW-2:0]       rem_q;
  logic [CWD-1:0]      dq_q;    // dividend bits shift out the top, quotient bits in at the bottom
  logic [W:0]          dvs_q;
  logic                neg_q;
  logic [CNTW-1:0]     cnt_q;

  logic [W:0]          sab, sbc, sac;
  logic                tri_ok;
  logic [2*W-1:0]      aa, bb, cc;
  logic [NW-1:0]       num, mag;
  logic [DW-1:0]       dividend;
  logic [RW-1:0]       trial;
  logic                ge;
  logic [RW-2:0]       rem_n;
  logic [CWD-1:0]      quo_n;
  logic [CWD:0]        cx_fin;
  logic [CWD-1:0]      bq;
  logic [2*CWD-1:0]    bsq, qsq, radicand;
  logic                div_last;
  logic                sq_start;
  logic                sq_done;
  logic [CWD-1:0]      sq_root;

  always_comb begin
    sab    = {1'b0, ra} + {1'b0, rb};
    sbc    = {1'b0, rb} + {1'b0, rc};
    sac    = {1'b0, ra} + {1'b0, rc};
    tri_ok = (sab > {1'b0, rc}) && (sbc > {1'b0, ra}) && (sac > {1'b0, rb});

    aa       = {{W{1'b0}}, ra} * {{W{1'b0}}, ra};
    bb       = {{W{1'b0}}, rb} * {{W{1'b0}}, rb};
    cc       = {{W{1'b0}}, rc} * {{W{1'b0}}, rc};
    num      = {2'b00, bb} + {2'b00, cc} - {2'b00, aa};
    mag      = num[NW-1] ? -num : num;
    dividend = {mag, {FRAC{1'b0}}};

    trial    = {rem_q, dq_q[CWD-1]};
    ge       = (trial >= {2'b00, dvs_q});
    rem_n    = ge ? (RW-1)'(trial - {2'b00, dvs_q}) : trial[RW-2:0];
    quo_n    = {dq_q[CWD-2:0], ge};
    cx_fin   = neg_q ? -{1'b0, quo_n} : {1'b0, quo_n};

    // Radicand uses the final quotient directly so the root can start on the
    // same edge the last quotient bit resolves.
    bq       = {rb, {FRAC{1'b0}}};
    bsq      = {{CWD{1'b0}}, bq} * {{CWD{1'b0}}, bq};
    qsq      = {{CWD{1'b0}}, quo_n} * {{CWD{1'b0}}, quo_n};
    radicand = (bsq >= qsq) ? (bsq - qsq) : '0;

    div_last = (cnt_q == CNTW'(CWD - 1));
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sq_start  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = CHECK;
      end
      CHECK: state_n = tri_ok ? DIV : DONE;
      DIV: begin
        if (div_last) begin
          sq_start = 1'b1;
          state_n  = SQRT;
        end
      end
      SQRT: begin
        if (sq_done) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      rem_q <= '0;
      dq_q  <= '0;
      dvs_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      bx    <= '0;
      cx    <= '0;
      cy    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra <= side_a;
            rb <= side_b;
            rc <= side_c;
          end
        end
        CHECK: begin
          if (!tri_ok) begin
            err <= 1'b1;
            bx  <= '0;
            cx  <= '0;
            cy  <= '0;
          end else begin
            err   <= 1'b0;
            bx    <= {1'b0, rc, {FRAC{1'b0}}};
            rem_q <= dividend[DW-1:CWD];
            dq_q  <= dividend[CWD-1:0];
            dvs_q <= {rc, 1'b0};
            neg_q <= num[NW-1];
            cnt_q <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_n;
          dq_q  <= quo_n;
          cnt_q <= cnt_q + CNTW'(1);
          if (div_last) cx <= cx_fin;
        end
        SQRT: begin
          if (sq_done) cy <= sq_root;
        end
        default: ;
      endcase
    end
  end

  isqrt_seq #(
    .ROOT_W (CWD)
  ) u_isqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sq_start),
    .radicand (radicand),
    .done     (sq_done),
    .root     (sq_root)
  );

endmodule

// File: tb/tb_tri_from_sides.sv
// tb/tb_tri_from_sides.sv - self-checking bench for tri_from_sides
module tb_tri_from_sides;

  localparam int W    = 8;
  localparam int FRAC = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        side_a = '0;
  logic [W-1:0]        side_b = '0;
  logic [W-1:0]        side_c = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [W+FRAC:0]     bx;
  logic [W+FRAC:0]     cx;
  logic [W+FRAC-1:0]   cy;
  logic                err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tri_from_sides #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .side_a    (side_a),
    .side_b    (side_b),
    .side_c    (side_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bx        (bx),
    .cx        (cx),
    .cy        (cy),
    .err       (err)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Geometry straight from the side lengths with plain integer arithmetic.
  function automatic void model(input int a, input int b, input int c,
                                output int e, output int ebx, output int ecx, output int ecy);
    longint num, q, r, s, scale;
    scale = longint'(1) << FRAC;
    if (!((a + b > c) && (b + c > a) && (a + c > b))) begin
      e = 1; ebx = 0; ecx = 0; ecy = 0;
      return;
    end
    e   = 0;
    ebx = c * int'(scale);
    num = longint'(b*b + c*c - a*a);
    q   = ((num < 0) ? -num : num) * scale / (2 * c);
    ecx = int'((num < 0) ? -q : q);
    r   = (b * scale) * (b * scale) - longint'(ecx) * longint'(ecx);
    if (r < 0) r = 0;
    s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    ecy = int'(s);
  endfunction

  function automatic int cx_int();
    logic signed [W+FRAC:0] v;
    v = cx;
    return int'(v);
  endfunction

  task automatic send(input int a, input int b, input int c);
    int n;
    @(negedge clk);
    side_a   = W'(a);
    side_b   = W'(b);
    side_c   = W'(c);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    side_a   = W'($urandom);
    side_b   = W'($urandom);
    side_c   = W'($urandom);
  endtask

  task automatic wait_result(input string tag, input int a, input int b, input int c);
    int e, ebx, ecx, ecy, lat;
    model(a, b, c, e, ebx, ecx, ecy);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, (e != 0) ? 2 : 26);
    check({tag, "_err"}, int'(err), e);
    check({tag, "_bx"}, int'(bx), ebx);
    check({tag, "_cx"}, cx_int(), ecx);
    check({tag, "_cy"}, int'(cy), ecy);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  task automatic run(input string tag, input int a, input int b, input int c);
    send(a, b, c);
    wait_result(tag, a, b, c);
    release_result(tag);
  endtask

  initial begin
    int e, ebx, ecx, ecy;
    int a, b, c, lo, hi;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_bx", int'(bx), 0);
    check("rst_cx", int'(cx), 0);
    check("rst_cy", int'(cy), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed triangles, including constant cross-checks of the model.
    model(4, 3, 5, e, ebx, ecx, ecy);
    check("const_345_cx", ecx, 28);
    check("const_345_cy", ecy, 38);
    run("t345", 4, 3, 5);
    run("equi", 10, 10, 10);
    model(10, 3, 8, e, ebx, ecx, ecy);
    check("const_obtuse_cx", ecx, -27);
    run("obtuse", 10, 3, 8);
    run("degen", 5, 2, 3);
    run("c_zero", 5, 5, 0);

    // Out_ready held high while idle must not matter.
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_hi", int'(in_ready), 1);
    out_ready = 1'b0;

    // Backpressure: hold the result, offer a competing triple.
    send(4, 3, 5);
    wait_result("bp", 4, 3, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      side_a = W'(10); side_b = W'(10); side_c = W'(10);
      @(posedge clk);
      #1;
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_bx", int'(bx), 80);
      check("bp_cx", cx_int(), 28);
      check("bp_cy", int'(cy), 38);
    end
    in_valid = 1'b0;
    release_result("bp");
    run("after_bp", 10, 10, 10);

    // Reset in the middle of the square root phase.
    send(10, 3, 8);
    repeat (18) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_cx", int'(cx), 0);
    check("midrst_cy", int'(cy), 0);
    check("midrst_bx", int'(bx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_rst", 10, 3, 8);

    // Random triples, mostly valid triangles with some arbitrary ones.
    for (int i = 0; i < 12; i++) begin
      b = int'($urandom_range(1, 255));
      c = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, 255));
      lo = ((b > c) ? (b - c) : (c - b)) + 1;
      hi = (b + c - 1 > 255) ? 255 : (b + c - 1);
      if ((i % 3) != 0 && lo <= hi) a = int'($urandom_range(hi, lo));
      run("rand", a, b, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_from_sides.md
Name: tri_from_sides

Overview:
- Inverse of the side-length computation: takes the three side lengths of a triangle and reconstructs vertex coordinates in a canonical frame.
  - A is fixed at the origin.
  - B lies on the +x axis.
  - C is in the upper half-plane.
- Multi-cycle, with valid/ready handshakes on both ends.
- Uses a sequential restoring divider for Cx and a bit-serial integer square root for Cy.
- Feeds the geometry checkers that re-derive side lengths from vertices.

Parameters:
- W, 8: width of each unsigned integer side input.
- FRAC, 4: fractional bits of the fixed-point coordinate outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  side triple is valid.
- in_ready  out  1  block can accept a triple.
- side_a  in  W  unsigned, length BC.
- side_b  in  W  unsigned, length CA.
- side_c  in  W  unsigned, length AB.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- bx  out  W+FRAC+1  signed, B.x = side_c<<FRAC (B.y is always 0).
- cx  out  W+FRAC+1  signed, C.x in Q(FRAC).
- cy  out  W+FRAC  unsigned, C.y in Q(FRAC), always >= 0.
- err  out  1  the triple does not form a non-degenerate triangle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, bx=cx=cy=0, err=0.
  - Reset mid-computation aborts the job; no partial result is ever presented.
- FSM states: IDLE, CHECK, DIV, SQRT, DONE.
- IDLE:
  - in_ready=1; in_ready is 0 in all other states.
  - On in_valid&in_ready, register a,b,c and go to CHECK. Later input changes are ignored.
- CHECK (1 cycle):
  - Require strict triangle inequality: a+b>c, b+c>a, a+c>b, using W+1-bit sums. This also rejects c=0.
  - On failure: err=1, bx=cx=cy=0, go to DONE.
  - Otherwise: compute num = b²+c²−a² (signed, 2W+2 bits), load the divider with |num|<<FRAC and divisor 2c, record the sign, go to DIV.
- DIV (W+FRAC cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - Quotient is the magnitude truncated toward zero; cx = sign ? −q : q.
  - At the end, load the radicand R = (b<<FRAC)² − cx² (2(W+FRAC) bits). If R would be negative, clamp it to 0.
  - Go to SQRT.
- SQRT (W+FRAC cycles):
  - Bit-serial floor integer square root, one result bit per cycle; cy = floor(sqrt(R)).
  - Go to DONE.
- DONE:
  - out_valid=1. bx, cx, cy, err are stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE. out_valid falls on the next edge.
- Latency from the accepting edge to out_valid=1:
  - Normal: 2+2·(W+FRAC) = 26 cycles at the defaults.
  - Error: 2 cycles.
- Throughput: one triple in flight; no new acceptance before the result handshake completes.
- Outputs keep their last value in IDLE. Only the out_valid qualification matters.
- out_ready held high while idle has no effect.

Decomposition:
- Shared package tri_pkg holds:
  - the state enum (IDLE, CHECK, DIV, SQRT, DONE);
  - default W and FRAC;
  - a derived constant CW = W+FRAC.
- One natural sub-module, isqrt_seq: start/done handshake, radicand 2·CW bits, result CW bits, CW cycles. It is reusable for the distance block's square root.
- The divider stays inline in this module.

Test Plan:
- a=4, b=3, c=5 -> after 26 cycles: out_valid=1, bx=80, cx=28, cy=38, err=0.
- a=b=c=10 -> bx=160, cx=80, cy=138, err=0.
- Obtuse, a=10, b=3, c=8 -> bx=128, cx=−27, cy=39, err=0.
- Degenerate, a=5, b=2, c=3 -> out_valid after 2 cycles, err=1, bx=cx=cy=0. Repeat with c=0 -> err=1.
- Backpressure:
  - hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is not accepted;
  - release -> IDLE, in_ready=1, next triple accepted.
- Pull rst_n low during SQRT -> immediately out_valid=0, outputs 0, in_ready=1; a fresh triple then completes with correct values.
